// File: rtl/uart_report_scheduler_if.sv
// Byte-wide UART TX stream: scheduler offers bytes, sender accepts them.
// Stream is valid/ready; data holds while valid is high and ready is low.
interface uart_report_scheduler_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/uart_report_scheduler.sv
// Arbitrates gesture and telemetry reports onto one framed UART byte stream.
// Telemetry requester, snapshot and 12-byte packet exist only with UART_TELEMETRY_EN.
module uart_report_scheduler #(
   parameter int unsigned TELEM_PERIOD_CYCLES = 600_000,
   parameter logic [7:0]  HDR_GESTURE         = 8'hA5,
   parameter logic [7:0]  HDR_TELEM           = 8'h5A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gesture_valid,
   input  logic [1:0]  gesture_class,
   input  logic [7:0]  gesture_confidence,
   input  logic [23:0] telem_m00,
   input  logic [23:0] telem_m10,
   input  logic [23:0] telem_m01,
   input  logic [2:0]  telem_state,
   uart_report_scheduler_if.master tx,
   output logic        busy,
   output logic        pkt_dropped
);

   typedef enum logic {
      S_IDLE,
      S_SEND
   } state_t;

   state_t      state;
   logic        g_pend;
   logic        t_pend;
   logic [1:0]  g_cls;
   logic [7:0]  g_conf;
   logic [79:0] sh;
   logic [7:0]  xsum;
   logic [3:0]  idx;
   logic [3:0]  last_idx;
   logic        hs;
   logic        grant_g;

   assign hs      = tx.tx_valid && tx.tx_ready;
   assign grant_g = (state == S_IDLE) && g_pend;

   // New payload always lands; a grant this cycle took the old one.
   always_ff @(posedge clk) begin
      if (rst) begin
         g_pend      <= 1'b0;
         g_cls       <= '0;
         g_conf      <= '0;
         pkt_dropped <= 1'b0;
      end else begin
         pkt_dropped <= gesture_valid && g_pend && !grant_g;
         if (gesture_valid) begin
            g_cls  <= gesture_class;
            g_conf <= gesture_confidence;
            g_pend <= 1'b1;
         end else if (grant_g) begin
            g_pend <= 1'b0;
         end
      end
   end

`ifdef UART_TELEMETRY_EN
   localparam int TW = $clog2(TELEM_PERIOD_CYCLES);

   logic [TW-1:0] timer;
   logic          t_wrap;
   logic          grant_t;

   assign t_wrap  = timer == TW'(TELEM_PERIOD_CYCLES - 1);
   assign grant_t = (state == S_IDLE) && !g_pend && t_pend;

   // A wrap coinciding with a grant raises a fresh request.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer  <= '0;
         t_pend <= 1'b0;
      end else begin
         timer <= t_wrap ? '0 : timer + 1'b1;
         if (t_wrap) begin
            t_pend <= 1'b1;
         end else if (grant_t) begin
            t_pend <= 1'b0;
         end
      end
   end
`else
   logic unused_telem;

   assign t_pend       = 1'b0;
   assign unused_telem = ^{telem_m00, telem_m10, telem_m01,
                           telem_state, HDR_TELEM, t_pend,
                           TELEM_PERIOD_CYCLES[0]};
`endif

   // sh holds the bytes after the header; the last byte is the running XOR.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         tx.tx_valid <= 1'b0;
         tx.tx_data  <= '0;
         busy        <= 1'b0;
         sh          <= '0;
         xsum        <= '0;
         idx         <= '0;
         last_idx    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (grant_g) begin
                  state       <= S_SEND;
                  tx.tx_valid <= 1'b1;
                  tx.tx_data  <= HDR_GESTURE;
                  busy        <= 1'b1;
                  sh          <= {6'b0, g_cls, g_conf, 64'b0};
                  xsum        <= '0;
                  idx         <= '0;
                  last_idx    <= 4'd3;
`ifdef UART_TELEMETRY_EN
               end else if (grant_t) begin
                  state       <= S_SEND;
                  tx.tx_valid <= 1'b1;
                  tx.tx_data  <= HDR_TELEM;
                  busy        <= 1'b1;
                  sh          <= {telem_m00, telem_m10, telem_m01,
                                  5'b0, telem_state};
                  xsum        <= '0;
                  idx         <= '0;
                  last_idx    <= 4'd11;
`endif
               end
            end
            S_SEND: begin
               if (hs) begin
                  xsum <= xsum ^ tx.tx_data;
                  idx  <= idx + 4'd1;
                  sh   <= sh << 8;
                  if (idx == last_idx) begin
                     state       <= S_IDLE;
                     tx.tx_valid <= 1'b0;
                     tx.tx_data  <= '0;
                     busy        <= 1'b0;
                  end else if (idx == last_idx - 4'd1) begin
                     tx.tx_data <= xsum ^ tx.tx_data;
                  end else begin
                     tx.tx_data <= sh[79:72];
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_report_scheduler.sv
// Directed bench for uart_report_scheduler: framing, latency, backpressure,
// overwrite, back-to-back, reset abort and (when compiled in) telemetry.
module tb_uart_report_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        gesture_valid;
   logic [1:0]  gesture_class;
   logic [7:0]  gesture_confidence;
   logic [23:0] telem_m00;
   logic [23:0] telem_m10;
   logic [23:0] telem_m01;
   logic [2:0]  telem_state;
   logic        busy;
   logic        pkt_dropped;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_report_scheduler_if bus ();

   uart_report_scheduler #(
      .TELEM_PERIOD_CYCLES(64)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .gesture_valid     (gesture_valid),
      .gesture_class     (gesture_class),
      .gesture_confidence(gesture_confidence),
      .telem_m00         (telem_m00),
      .telem_m10         (telem_m10),
      .telem_m01         (telem_m01),
      .telem_state       (telem_state),
      .tx                (bus),
      .busy              (busy),
      .pkt_dropped       (pkt_dropped)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      gesture_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.tx_ready = 1'b1;
      tick();
      tick();
      n_tests++;
      if (bus.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid);
      end
      n_tests++;
      if (bus.tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_tx_data: got %02h want 00", bus.tx_data);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_tests++;
      if (pkt_dropped !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dropped: got %b want 0", pkt_dropped);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_gesture();
      logic [7:0] e [4];
      e = '{8'hA5, 8'h02, 8'h40, 8'hE7};
      do_reset();
      bus.tx_ready = 1'b1;
      gesture_valid = 1'b1;
      gesture_class = 2'd2;
      gesture_confidence = 8'h40;
      tick();
      gesture_valid = 1'b0;
      n_tests++;
      if (bus.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early: tx_valid=%b want 0", bus.tx_valid);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (bus.tx_valid !== 1'b1 || bus.tx_data !== e[i] || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_byte%0d: v=%b d=%02h busy=%b want v=1 d=%02h busy=1",
                     i, bus.tx_valid, bus.tx_data, busy, e[i]);
         end
         tick();
      end
      n_tests++;
      if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_end: busy=%b v=%b want 0 0", busy, bus.tx_valid);
      end
   endtask

   task automatic test_backpressure();
      logic stable;
      do_reset();
      bus.tx_ready = 1'b1;
      gesture_valid = 1'b1;
      gesture_class = 2'd2;
      gesture_confidence = 8'h40;
      tick();
      gesture_valid = 1'b0;
      tick();
      tick();
      bus.tx_ready = 1'b0;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h02) stable = 1'b0;
         tick();
      end
      n_tests++;
      if (stable !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_hold: byte1 not held, got %02h want 02", bus.tx_data);
      end
      bus.tx_ready = 1'b1;
      n_tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h02) begin
         n_fail++;
         $display("FAIL bp_byte1: got %02h want 02", bus.tx_data);
      end
      tick();
      n_tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h40) begin
         n_fail++;
         $display("FAIL bp_byte2: got %02h want 40", bus.tx_data);
      end
      tick();
      n_tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hE7) begin
         n_fail++;
         $display("FAIL bp_byte3: got %02h want E7", bus.tx_data);
      end
      tick();
      n_tests++;
      if (bus.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_extra: tx_valid=%b want 0", bus.tx_valid);
      end
   endtask

   task automatic test_overwrite();
      logic [7:0] e [9];
      e = '{8'hA5, 8'h01, 8'h11, 8'hB5, 8'h00,
            8'hA5, 8'h03, 8'h77, 8'hD1};
      do_reset();
      bus.tx_ready = 1'b0;
      gesture_valid = 1'b1;
      gesture_class = 2'd1;
      gesture_confidence = 8'h11;
      tick();
      gesture_valid = 1'b0;
      tick();
      gesture_valid = 1'b1;
      gesture_class = 2'd0;
      gesture_confidence = 8'h22;
      tick();
      gesture_class = 2'd3;
      gesture_confidence = 8'h77;
      n_tests++;
      if (pkt_dropped !== 1'b0) begin
         n_fail++;
         $display("FAIL ow_first: dropped=%b want 0", pkt_dropped);
      end
      tick();
      gesture_valid = 1'b0;
      n_tests++;
      if (pkt_dropped !== 1'b1) begin
         n_fail++;
         $display("FAIL ow_pulse: dropped=%b want 1", pkt_dropped);
      end
      tick();
      n_tests++;
      if (pkt_dropped !== 1'b0) begin
         n_fail++;
         $display("FAIL ow_once: dropped=%b want 0", pkt_dropped);
      end
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         n_tests++;
         if (i == 4) begin
            if (bus.tx_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL ow_gap: tx_valid=%b want 0", bus.tx_valid);
            end
         end else if (bus.tx_valid !== 1'b1 || bus.tx_data !== e[i]) begin
            n_fail++;
            $display("FAIL ow_byte%0d: v=%b d=%02h want v=1 d=%02h",
                     i, bus.tx_valid, bus.tx_data, e[i]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e [9];
      e = '{8'hA5, 8'h01, 8'h10, 8'hB4, 8'h00,
            8'hA5, 8'h02, 8'h20, 8'h87};
      do_reset();
      bus.tx_ready = 1'b1;
      gesture_valid = 1'b1;
      gesture_class = 2'd1;
      gesture_confidence = 8'h10;
      tick();
      gesture_class = 2'd2;
      gesture_confidence = 8'h20;
      tick();
      gesture_valid = 1'b0;
      n_tests++;
      if (pkt_dropped !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_nodrop: dropped=%b want 0", pkt_dropped);
      end
      for (int i = 0; i < 9; i++) begin
         n_tests++;
         if (i == 4) begin
            if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_gap: v=%b busy=%b want 0 0", bus.tx_valid, busy);
            end
         end else if (bus.tx_valid !== 1'b1 || bus.tx_data !== e[i]) begin
            n_fail++;
            $display("FAIL b2b_byte%0d: v=%b d=%02h want v=1 d=%02h",
                     i, bus.tx_valid, bus.tx_data, e[i]);
         end
         tick();
      end
      n_tests++;
      if (bus.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: tx_valid=%b want 0", bus.tx_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      do_reset();
      bus.tx_ready = 1'b0;
      gesture_valid = 1'b1;
      gesture_class = 2'd1;
      gesture_confidence = 8'h05;
      tick();
      gesture_class = 2'd2;
      gesture_confidence = 8'h06;
      tick();
      gesture_valid = 1'b0;
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      n_tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h01) begin
         n_fail++;
         $display("FAIL rm_pre: v=%b d=%02h want 1 01", bus.tx_valid, bus.tx_data);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_abort: v=%b busy=%b want 0 0", bus.tx_valid, busy);
      end
      rst = 1'b0;
      bus.tx_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.tx_valid !== 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_residual: packet after reset, got 1 want 0");
      end
   endtask

`ifdef UART_TELEMETRY_EN
   task automatic test_telemetry();
      logic [7:0] e [12];
      int k;
      e = '{8'h5A, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00,
            8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h05, 8'hD0};
      telem_m00 = 24'h123456;
      telem_m10 = 24'h000000;
      telem_m01 = 24'hFFFFFF;
      telem_state = 3'd5;
      do_reset();
      bus.tx_ready = 1'b1;
      k = 0;
      while (bus.tx_valid !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      n_tests++;
      if (k != 65) begin
         n_fail++;
         $display("FAIL tel_first: header after %0d cycles want 65", k);
      end
      for (int i = 0; i < 12; i++) begin
         if (i == 1) telem_m00 = 24'hABCDEF;
         n_tests++;
         if (bus.tx_valid !== 1'b1 || bus.tx_data !== e[i]) begin
            n_fail++;
            $display("FAIL tel_byte%0d: v=%b d=%02h want v=1 d=%02h",
                     i, bus.tx_valid, bus.tx_data, e[i]);
         end
         tick();
      end
      k = 0;
      while (bus.tx_valid !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      n_tests++;
      if (k != 52 || bus.tx_data !== 8'h5A) begin
         n_fail++;
         $display("FAIL tel_period: gap %0d hdr %02h want 52 5A", k, bus.tx_data);
      end
      tick();
      n_tests++;
      if (bus.tx_data !== 8'hAB) begin
         n_fail++;
         $display("FAIL tel_snapshot: got %02h want AB", bus.tx_data);
      end
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_priority();
      do_reset();
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 63; i++) tick();
      gesture_valid = 1'b1;
      gesture_class = 2'd3;
      gesture_confidence = 8'h01;
      tick();
      gesture_valid = 1'b0;
      tick();
      n_tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL prio_first: d=%02h want A5", bus.tx_data);
      end
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if (bus.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_gap: tx_valid=%b want 0", bus.tx_valid);
      end
      tick();
      n_tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h5A) begin
         n_fail++;
         $display("FAIL prio_second: d=%02h want 5A", bus.tx_data);
      end
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_reset_telem();
      logic seen;
      do_reset();
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 71; i++) tick();
      n_tests++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL rt_byte6: v=%b d=%02h want 1 00", bus.tx_valid, bus.tx_data);
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if (bus.tx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rt_abort: tx_valid=%b want 0", bus.tx_valid);
      end
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (bus.tx_valid !== 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL rt_residual: packet after reset, got 1 want 0");
      end
   endtask
`else
   task automatic test_no_telemetry();
      logic seen;
      do_reset();
      bus.tx_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (bus.tx_valid !== 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL no_telem: unexpected packet, got 1 want 0");
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      gesture_valid = 1'b0;
      gesture_class = 2'd0;
      gesture_confidence = 8'h00;
      telem_m00 = 24'h0;
      telem_m10 = 24'h0;
      telem_m01 = 24'h0;
      telem_state = 3'd0;
      bus.tx_ready = 1'b0;
      test_reset();
      test_single_gesture();
      test_backpressure();
      test_overwrite();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_TELEMETRY_EN
      test_telemetry();
      test_priority();
      test_reset_telem();
`else
      test_no_telemetry();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_report_scheduler.md
# uart_report_scheduler

- Schedules and serializes all outbound UART reports onto the single byte-wide transmit path.
- Shares that path between two requesters:
  - gesture result packets, event-driven, high priority;
  - periodic moment/state telemetry packets, timer-driven, low priority.
- Sits between `gradient_map_core` outputs and the UART TX byte sender.
- Owns arbitration, packet framing, checksum generation and overwrite/drop accounting.

## Interface
Parameters:
- `TELEM_PERIOD_CYCLES`, default 600_000: telemetry request interval in clk cycles (50 ms at 12 MHz); legal range ≥ 16.
- `HDR_GESTURE`, default 8'hA5: header byte of a gesture packet.
- `HDR_TELEM`, default 8'h5A: header byte of a telemetry packet.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `gesture_valid` in 1: one-cycle pulse carrying a new classification.
- `gesture_class` in 2: class code, sampled when `gesture_valid` is high.
- `gesture_confidence` in 8: confidence, sampled when `gesture_valid` is high.
- `telem_m00`, `telem_m10`, `telem_m01` in 24 each: moment values, sampled at telemetry grant.
- `telem_state` in 3: core state, sampled at telemetry grant.
- `tx_data` out 8: byte offered to the UART TX sender.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sender accepts the byte this cycle.
- `busy` out 1: a packet is in flight.
- `pkt_dropped` out 1: one-cycle pulse when an unsent gesture is overwritten.

## Operation
Gesture packet, 4 bytes, sent in this order:
- `HDR_GESTURE`
- `{6'b0, class}`
- `confidence`
- XOR of the three preceding bytes

Telemetry packet, 12 bytes, sent in this order:
- `HDR_TELEM`
- `m00` MSB-first (3 bytes), then `m10` MSB-first (3 bytes), then `m01` MSB-first (3 bytes)
- `{5'b0, state}`
- XOR of the 11 preceding bytes

Gesture requester:
- One-deep pending latch. `gesture_valid` writes class and confidence and sets `g_pend`.
- If `g_pend` is already set and not granted in the same cycle, the new data overwrites the old and `pkt_dropped` pulses the next cycle.
- A grant in the same cycle as `gesture_valid`: the packet uses the old latched payload, the new payload stays pending, and no drop is reported.

Telemetry requester:
- Free-running counter 0..`TELEM_PERIOD_CYCLES`-1. Reaching the wrap point sets `t_pend`.
- Wraps while `t_pend` is already set are absorbed silently.
- Inputs are snapshotted into the payload register on grant, not when the request is raised.

States:
- **IDLE**
  - If `g_pend` is set: grant gesture, load payload, clear `g_pend`, go to SEND.
  - Else if `t_pend` is set: grant telemetry, snapshot inputs, clear `t_pend`, go to SEND.
  - Else stay in IDLE.
- **SEND**
  - Drive the byte at `idx` with `tx_valid` high.
  - On `tx_valid && tx_ready`: fold the byte into the running XOR and increment `idx`.
  - The checksum byte is the running XOR.
  - On the handshake of the last byte, go to IDLE.

Arbitration rules:
- No preemption: a gesture arriving during a telemetry packet waits for that packet to finish.
- Gesture wins every tie.

## Timing
Reset values:
- Outputs: `tx_valid`=0, `tx_data`=0, `busy`=0, `pkt_dropped`=0.
- Internal: `g_pend`=0, `t_pend`=0, timer=0, state IDLE.

Latency and throughput:
- `gesture_valid` in cycle N with the scheduler idle: first header byte appears with `tx_valid` high in cycle N+2.
- After the last handshake, the next packet's header can appear 2 cycles later (one IDLE cycle).
- `busy` is high from the grant cycle+1 through the cycle of the last handshake.

Handshake:
- Once `tx_valid` rises, it and `tx_data` stay stable until `tx_ready` is seen.
- `tx_ready` is ignored while `tx_valid` is low.

Reset mid-packet:
- Aborts the packet; `tx_valid` is 0 in the following cycle.
- Both pending flags are cleared and the timer restarts from 0.

## Configuration
- `UART_TELEMETRY_EN` defined: telemetry timer, snapshot register and 12-byte packet are compiled in.
- `UART_TELEMETRY_EN` undefined:
  - only gesture packets are emitted;
  - `telem_*` inputs are unused;
  - `t_pend` is tied to 0;
  - the timer is removed.

## Test plan
- **Single gesture.** Always-ready sink; `gesture_valid`, class=2, conf=8'h40 -> bytes A5,02,40,E7. First byte in cycle N+2; `busy` falls after the 4th handshake.
- **Backpressure.** Hold `tx_ready`=0 for 10 cycles during byte 1 -> `tx_data`=02 stays stable; no byte is lost or duplicated.
- **Overwrite.** With `tx_ready`=0 and a packet in flight, send gestures class=0 then class=3 -> `pkt_dropped` pulses once; the next packet is A5,03,conf,checksum.
- **Telemetry.** `TELEM_PERIOD_CYCLES`=64, m00=24'h123456, m10=0, m01=24'hFFFFFF, state=5 -> a 12-byte packet with the correct XOR every 64 cycles.
- **Priority.** Gesture and telemetry requests pending together -> gesture packet first, telemetry packet after one idle cycle.
- **Reset.** Assert `rst` mid-telemetry at byte 6 -> `tx_valid`=0 the next cycle; no residual packet after release until a new request arrives.
